uart_rx_byte: RTL and testbench

- Receives 8N1 serial data from the FTDI line (ftdi_txd at top level) and presents whole bytes to the terminal character/escape parser through a valid/ready handshake.
- Sits between the top-level pin and the parser stage that drives the HDMI text renderer.
- Provides 2-flop synchronisation, mid-bit sampling, start-glitch rejection, a one-byte holding register, and framing-error and overrun reporting.

---
 rtl/uart_defs.sv | 25 ++
 rtl/uart_sync2.sv | 36 +++
 rtl/uart_rx_byte.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// ---------------------------------------------------------------------------
// uart_defs
// Shared definitions for the UART receive path: FSM state encoding, frame
// width, default bit period for a 25 MHz clock at 115200 baud, and the
// three-input majority voter used by the optional majority-sampling build.
// ---------------------------------------------------------------------------
package uart_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 217;

    // Two-of-three vote over consecutive samples of the synchronised line.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous input. The flops reset to
// RESET_VAL so an idle-high line does not look like activity out of reset.
// Ports:
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low reset
//   d      in  1  asynchronous input
//   q      out 1  d delayed by two clk flops
// ---------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver feeding the terminal parser through a valid/ready
// handshake. The line is sampled at mid-bit; a start bit that is high again
// at its mid-sample is treated as a glitch. A low stop bit raises a framing
// error and the receiver waits for the line to go high before re-arming, so
// a break does not retrigger reception. One received byte is held; a byte
// completed while the holding register is full and not being accepted is
// dropped with an overrun pulse.
//
// Build option: define UART_RX_MAJORITY_EN to decide every start/data/stop
// sample by majority of the last three synchronised line values.
//
// Ports:
//   clk_25mhz    in  1  system clock
//   rst_n        in  1  asynchronous active-low reset
//   rx_i         in  1  raw serial line, idle high, asynchronous
//   data_o       out 8  received byte
//   valid_o      out 1  data_o holds an unconsumed byte
//   ready_i      in  1  consumer accepts data_o when valid_o & ready_i
//   frame_err_o  out 1  one-cycle pulse: stop bit sampled low
//   overrun_o    out 1  one-cycle pulse: byte dropped, holding register full
//   busy_o       out 1  receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_byte
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk_25mhz,
    input  logic                      rst_n,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      frame_err_o,
    output logic                      overrun_o,
    output logic                      busy_o
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    // Counters are loaded with (period - 1) and the sample is taken at zero,
    // so a load of HALF_BIT-1 puts the start sample HALF_BIT cycles after the
    // first low cycle, and CLKS_PER_BIT-1 spaces later samples one bit apart.
    localparam logic [15:0] HALF_LOAD = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    logic                      sample_s;

    uart_state_e               state_r;
    uart_state_e               state_next_s;
    logic [15:0]               cnt_r;
    logic [15:0]               cnt_next_s;
    logic [2:0]                bit_r;
    logic [2:0]                bit_next_s;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [UART_DATA_BITS-1:0] shift_next_s;
    logic                      deliver_s;
    logic                      ferr_s;
    logic                      load_s;
    logic                      overrun_s;

    logic [UART_DATA_BITS-1:0] data_r;
    logic                      valid_r;
    logic                      ferr_r;
    logic                      overrun_r;
    logic                      busy_r;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk_25mhz),
        .rst_n (rst_n),
        .d     (rx_i),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist_r[0] is rx_s one cycle ago, hist_r[1] two cycles ago.
    logic [1:0] hist_r;

    // Short history of the synchronised line for the majority voter.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], rx_s};
        end
    end

    assign sample_s = majority3(rx_s, hist_r[0], hist_r[1]);
`else
    assign sample_s = rx_s;
`endif

    // Receive FSM state, bit timing and shift register.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            bit_r   <= 3'd0;
            shift_r <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            bit_r   <= bit_next_s;
            shift_r <= shift_next_s;
        end
    end

    // Next-state, bit timing and sample decisions.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        bit_next_s   = bit_r;
        shift_next_s = shift_r;
        deliver_s    = 1'b0;
        ferr_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Edge detection uses the raw synchronised line so the
                // sample schedule is anchored to the first low cycle.
                if (!rx_s) begin
                    cnt_next_s   = HALF_LOAD;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == 16'd0) begin
                    if (!sample_s) begin
                        bit_next_s   = 3'd0;
                        cnt_next_s   = BIT_LOAD;
                        state_next_s = ST_DATA;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_r == 16'd0) begin
                    shift_next_s[bit_r] = sample_s;
                    cnt_next_s          = BIT_LOAD;
                    if (bit_r == LAST_BIT) begin
                        state_next_s = ST_STOP;
                    end else begin
                        bit_next_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                end
            end
            ST_STOP: begin
                // Returning to IDLE at the stop mid-sample leaves half a bit
                // to spot the next start edge of a back-to-back frame.
                if (cnt_r == 16'd0) begin
                    if (sample_s) begin
                        deliver_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        ferr_s       = 1'b1;
                        state_next_s = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // A finished byte loads if the holder is empty or is being drained in
    // the same cycle; otherwise it is dropped.
    assign load_s    = deliver_s & (~valid_r | ready_i);
    assign overrun_s = deliver_s & valid_r & ~ready_i;

    // Holding register, handshake and status outputs.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            data_r    <= '0;
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            overrun_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            if (load_s) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
            end else if (valid_r && ready_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            ferr_r    <= ferr_s;
            overrun_r <= overrun_s;
            busy_r    <= (state_next_s != ST_IDLE);
        end
    end

    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign frame_err_o = ferr_r;
    assign overrun_o   = overrun_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_byte
// Directed bench for uart_rx_byte with CLKS_PER_BIT = 16. Inputs change 1 ns
// after the rising edge; a negedge monitor records accepted bytes, valid
// pulse widths and error pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int CPB = 16;

    logic       clk_25mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx_i      = 1'b1;
    logic       ready_i   = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    always #20 clk_25mhz = ~clk_25mhz;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_25mhz   (clk_25mhz),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_25mhz) cyc++;

    logic [7:0] got_q[$];
    int         vrun       = 0;
    int         last_run   = 0;
    int         ferr_cnt   = 0;
    int         ovr_cnt    = 0;
    int         rise_cyc   = 0;
    logic       prev_valid = 1'b0;

    always @(negedge clk_25mhz) begin
        if (valid_o && !prev_valid) rise_cyc = cyc;
        prev_valid = valid_o;
        if (valid_o) begin
            vrun++;
            if (ready_i) got_q.push_back(data_o);
        end else begin
            if (vrun != 0) last_run = vrun;
            vrun = 0;
        end
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) tick();
    endtask

    int fall_cyc  = 0;
    int busy_lows = 0;

    // Drives one frame cycle by cycle; spike_at inverts the line for a
    // single cycle at that offset from the start edge (-1 for none).
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int spike_at);
        logic [9:0] bits;
        bits      = {stop_v, d, 1'b0};
        busy_lows = 0;
        for (int c = 0; c < 10 * CPB; c++) begin
            rx_i = bits[c / CPB] ^ (c == spike_at);
            if (c == 0) fall_cyc = cyc;
            tick();
            if (((c % CPB) == CPB - 1) && (c < 9 * CPB) && !busy_o) busy_lows++;
        end
    endtask

    initial begin
        logic [7:0] spike_exp;
`ifdef UART_RX_MAJORITY_EN
        spike_exp = 8'h00;
`else
        spike_exp = 8'h08;
`endif
        // Reset state
        repeat (3) tick();
        check_eq("rst_data", 32'(data_o), 32'h00);
        check_eq("rst_valid", 32'(valid_o), 32'h0);
        check_eq("rst_ferr", 32'(frame_err_o), 32'h0);
        check_eq("rst_ovr", 32'(overrun_o), 32'h0);
        check_eq("rst_busy", 32'(busy_o), 32'h0);
        rst_n = 1'b1;
        idle(10);

        // Single byte 0x55 with the consumer always ready
        send_frame(8'h55, 1'b1, -1);
        idle(20);
        check_eq("b55_count", 32'(got_q.size()), 32'd1);
        check_eq("b55_data", 32'(got_q[0]), 32'h55);
        check_eq("b55_width", 32'(last_run), 32'd1);
        check_eq("b55_latency", 32'(rise_cyc - fall_cyc), 32'd155);
        check_eq("b55_busy_in_frame", 32'(busy_lows), 32'd0);
        check_eq("b55_busy_after", 32'(busy_o), 32'h0);

        // Four-cycle low glitch on the idle line
        rx_i = 1'b0;
        repeat (4) tick();
        rx_i = 1'b1;
        repeat (11) tick();
        check_eq("glitch_busy", 32'(busy_o), 32'h0);
        idle(10);
        check_eq("glitch_no_byte", 32'(got_q.size()), 32'd1);
        check_eq("glitch_no_ferr", 32'(ferr_cnt), 32'd0);

        // 0xA3 with a low stop bit, then line held low (break)
        send_frame(8'hA3, 1'b0, -1);
        rx_i = 1'b0;
        repeat (40) tick();
        idle(40);
        check_eq("ferr_count", 32'(ferr_cnt), 32'd1);
        check_eq("ferr_no_byte", 32'(got_q.size()), 32'd1);
        send_frame(8'h41, 1'b1, -1);
        idle(20);
        check_eq("after_ferr_count", 32'(got_q.size()), 32'd2);
        check_eq("after_ferr_data", 32'(got_q[1]), 32'h41);

        // Overrun: consumer stalled across two frames
        ready_i = 1'b0;
        send_frame(8'h10, 1'b1, -1);
        idle(10);
        send_frame(8'h20, 1'b1, -1);
        idle(20);
        check_eq("ovr_data_held", 32'(data_o), 32'h10);
        check_eq("ovr_valid_held", 32'(valid_o), 32'h1);
        check_eq("ovr_count", 32'(ovr_cnt), 32'd1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_eq("ovr_valid_drop", 32'(valid_o), 32'h0);
        check_eq("ovr_accept_count", 32'(got_q.size()), 32'd3);
        check_eq("ovr_accept_data", 32'(got_q[2]), 32'h10);
        ready_i = 1'b1;
        idle(10);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h7E, 1'b1, -1);
        idle(30);
        check_eq("b2b_count", 32'(got_q.size()), 32'd6);
        check_eq("b2b_data0", 32'(got_q[3]), 32'h00);
        check_eq("b2b_data1", 32'(got_q[4]), 32'hFF);
        check_eq("b2b_data2", 32'(got_q[5]), 32'h7E);
        check_eq("b2b_ferr", 32'(ferr_cnt), 32'd1);
        check_eq("b2b_ovr", 32'(ovr_cnt), 32'd1);

        // One-cycle spike aligned with the data bit 3 sample point of 0x00
        send_frame(8'h00, 1'b1, 72);
        idle(20);
        check_eq("spike_count", 32'(got_q.size()), 32'd7);
        check_eq("spike_data", 32'(got_q[6]), 32'(spike_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
